// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default limits for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } sw_state_t;

    localparam int DEF_MAX_MIN = 59;
    localparam int DEF_MAX_SEC = 59;
    localparam int DEF_CNT_W   = 6;

endpackage

// File: rtl/sw_wrap_counter.sv
// Modulo-(MAX+1) up counter with synchronous clear; clear beats increment.
module sw_wrap_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (value == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            // >= so that an out-of-range value also falls back to 0
            value <= (value >= MAX_V) ? '0 : value + 1'b1;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/adjust FSM driving MM:SS counters and field blanking.
// Optional blink of the field being adjusted is built when STOPWATCH_BLINK_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             one_hz_tick,
    input  logic             two_hz_tick,
    input  logic             four_hz_tick,
    input  logic             pause_pulse,
    input  logic             clear_pulse,
    input  logic             adj,
    input  logic             sel,
    output logic [CNT_W-1:0] minutes,
    output logic [CNT_W-1:0] seconds,
    output logic             running,
    output logic             blank_min,
    output logic             blank_sec
);

    sw_state_t state, state_nx;
    logic      in_run, in_adj;
    logic      sec_inc, min_inc, sec_at_max, min_at_max;

    assign in_run = (state == ST_RUN);
    assign in_adj = (state == ST_ADJUST);

    // Carry into minutes only while running; adjust edits one field with no carry.
    assign sec_inc = (in_run & one_hz_tick) | (in_adj & two_hz_tick &  sel);
    assign min_inc = (in_run & one_hz_tick & sec_at_max) | (in_adj & two_hz_tick & ~sel);

    sw_wrap_counter #(.MAX(MAX_SEC), .W(CNT_W)) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clear_pulse),
        .inc    (sec_inc),
        .value  (seconds),
        .at_max (sec_at_max)
    );

    sw_wrap_counter #(.MAX(MAX_MIN), .W(CNT_W)) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clear_pulse),
        .inc    (min_inc),
        .value  (minutes),
        .at_max (min_at_max)
    );

    // A clear swallows a same-cycle pause press; the adj level still governs ADJUST.
    always_comb begin
        state_nx = state;
        if (adj)
            state_nx = ST_ADJUST;
        else if (in_adj)
            state_nx = ST_PAUSE;
        else if (pause_pulse && !clear_pulse)
            state_nx = in_run ? ST_PAUSE : ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == ST_RUN);
        end
    end

    logic unused_min_at_max;
    assign unused_min_at_max = min_at_max;

`ifdef STOPWATCH_BLINK_EN
    logic phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= 1'b0;
        else if (!in_adj)
            phase <= 1'b0;
        else if (four_hz_tick)
            phase <= ~phase;
    end

    assign blank_min = in_adj & ~sel & phase;
    assign blank_sec = in_adj &  sel & phase;
`else
    logic unused_four_hz;
    assign unused_four_hz = four_hz_tick;
    assign blank_min      = 1'b0;
    assign blank_sec      = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; values are preset through adjust mode.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       one_hz_tick, two_hz_tick, four_hz_tick;
    logic       pause_pulse, clear_pulse, adj, sel;
    logic [5:0] minutes, seconds;
    logic       running, blank_min, blank_sec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .one_hz_tick  (one_hz_tick),
        .two_hz_tick  (two_hz_tick),
        .four_hz_tick (four_hz_tick),
        .pause_pulse  (pause_pulse),
        .clear_pulse  (clear_pulse),
        .adj          (adj),
        .sel          (sel),
        .minutes      (minutes),
        .seconds      (seconds),
        .running      (running),
        .blank_min    (blank_min),
        .blank_sec    (blank_sec)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int s, input int r);
        chk({tag, ".min"}, int'(minutes), m);
        chk({tag, ".sec"}, int'(seconds), s);
        chk({tag, ".run"}, int'(running), r);
    endtask

    // One clock with the given pulses; outputs are settled when it returns.
    task automatic cyc(input logic p1, input logic p2, input logic p4,
                       input logic pp, input logic cp);
        @(negedge clk);
        one_hz_tick = p1; two_hz_tick = p2; four_hz_tick = p4;
        pause_pulse = pp; clear_pulse = cp;
        @(posedge clk);
        #1;
        one_hz_tick = 0; two_hz_tick = 0; four_hz_tick = 0;
        pause_pulse = 0; clear_pulse = 0;
    endtask

    // Load m:s via adjust mode, then leave adjust so the FSM ends in PAUSE.
    task automatic preset(input int m, input int s);
        adj = 1'b1;
        cyc(0, 0, 0, 0, 1);
        sel = 1'b0;
        for (int i = 0; i < m; i++) cyc(0, 1, 0, 0, 0);
        sel = 1'b1;
        for (int i = 0; i < s; i++) cyc(0, 1, 0, 0, 0);
        adj = 1'b0;
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; one_hz_tick = 0; two_hz_tick = 0; four_hz_tick = 0;
        pause_pulse = 0; clear_pulse = 0; adj = 0; sel = 0;
        #12;
        chk_time("reset", 0, 0, 0);
        chk("reset.bmin", int'(blank_min), 0);
        chk("reset.bsec", int'(blank_sec), 0);
        @(negedge clk); rst_n = 1;

        // 1: start and count five seconds
        cyc(0, 0, 0, 1, 0);
        chk_time("start", 0, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("count.sec", int'(seconds), i);
        end
        chk_time("count5", 0, 5, 1);

        // 2: seconds carry and full wrap
        preset(0, 59);
        chk_time("preset59", 0, 59, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        chk_time("carry", 1, 0, 1);
        preset(59, 59);
        chk_time("preset5959", 59, 59, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        chk_time("wrap", 0, 0, 1);

        // 3: tick and pause in the same cycle
        preset(0, 10);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk_time("tick_pause", 0, 11, 0);
        cyc(1, 0, 0, 0, 0);
        chk_time("paused_tick", 0, 11, 0);

        // 4: seconds adjust wraps without carry; 1 Hz and pause ignored
        preset(0, 58);
        adj = 1; sel = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_time("adj_1hz_ign", 0, 58, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        chk_time("adj_wrap", 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("adj_pause_ign", int'(running), 0);
        adj = 0;
        cyc(0, 0, 0, 0, 0);
        chk_time("adj_exit", 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("exit_to_pause", int'(running), 1);
        cyc(0, 0, 0, 1, 0);

        // 5: blink on the minutes field
        adj = 1; sel = 0;
        cyc(0, 0, 0, 0, 0);
        chk("blink.entry", int'(blank_min), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0);
`ifdef STOPWATCH_BLINK_EN
            chk("blink.min", int'(blank_min), (i % 2 == 0) ? 1 : 0);
`else
            chk("blink.min", int'(blank_min), 0);
`endif
            chk("blink.sec", int'(blank_sec), 0);
        end
        adj = 0;
        cyc(0, 0, 0, 0, 0);
        chk("blink.exit", int'(blank_min), 0);

        // 6: clear beats tick, state kept; reset mid-adjust
        preset(12, 34);
        chk_time("preset1234", 12, 34, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1);
        chk_time("clear", 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        chk_time("after_clear", 0, 1, 1);
        adj = 1; sel = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("pre_rst.sec", int'(seconds), 2);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk_time("async_rst", 0, 0, 0);
        chk("async_rst.bmin", int'(blank_min), 0);
        chk("async_rst.bsec", int'(blank_sec), 0);
        adj = 0;
        @(negedge clk); rst_n = 1;
        cyc(1, 0, 0, 0, 0);
        chk_time("rst_paused", 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("rst_then_run", int'(running), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
